// File: rtl/dma_utils_pkg.sv
// dma_utils_pkg: types shared by the DMA sequencer and streamers.
// Descriptor count comes from the global `DMA_NUM_DESC (default 4 when undefined).
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 4
`endif

package dma_utils_pkg;

   localparam int unsigned DMA_NUM_DESC = `DMA_NUM_DESC;
   localparam int unsigned DMA_IDX_W    = (`DMA_NUM_DESC > 1) ? $clog2(`DMA_NUM_DESC) : 1;

   typedef logic [DMA_IDX_W-1:0] desc_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      CFG,
      RUN,
      DONE
   } dma_fsm_st_t;

   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [31:0] num_bytes;
      logic        enable;
   } s_dma_desc_t;

   typedef struct packed {
      logic      valid;
      desc_idx_t idx;
   } s_dma_str_in_t;

   typedef struct packed {
      logic done;
   } s_dma_str_out_t;

endpackage

// File: rtl/dma_fsm_desc_sel.sv
// dma_desc_sel: finds the lowest enabled, non-empty descriptor at or above a start index.
module dma_desc_sel
   import dma_utils_pkg::*;
(
   input  s_dma_desc_t [`DMA_NUM_DESC-1:0] i_desc,
   input  desc_idx_t                       i_start_idx,
   output logic                            o_found,
   output desc_idx_t                       o_idx
);

   logic      w_found;
   desc_idx_t w_idx;
   logic      w_unused_addr;

   // Single-cycle priority scan; first qualifying index wins
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned i = 0; i < DMA_NUM_DESC; i++) begin
         if (!w_found && (i >= 32'(i_start_idx)) &&
             i_desc[i].enable && (i_desc[i].num_bytes != '0)) begin
            w_found = 1'b1;
            w_idx   = desc_idx_t'(i);
         end
      end
   end

   // Address fields belong to the streamers; sink them so they are visibly ignored here
   always_comb begin
      w_unused_addr = 1'b0;
      for (int unsigned i = 0; i < DMA_NUM_DESC; i++) begin
         w_unused_addr = w_unused_addr ^ (^{i_desc[i].src_addr, i_desc[i].dst_addr});
      end
   end

   assign o_found = w_found;
   assign o_idx   = w_idx;

endmodule

// File: rtl/dma_fsm.sv
// dma_fsm: top-level DMA sequencer walking the descriptor array and launching
// the read/write streamers. Optional `DMA_ERR_ABORT_EN turns AXI errors into an abort.
module dma_fsm
   import dma_utils_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            dma_go_i,
   input  logic                            dma_abort_i,
   input  s_dma_desc_t [`DMA_NUM_DESC-1:0] dma_desc_i,
   input  logic                            dma_rd_err_i,
   input  logic                            dma_wr_err_i,
   output s_dma_str_in_t                   dma_stream_rd_o,
   output s_dma_str_in_t                   dma_stream_wr_o,
   input  s_dma_str_out_t                  dma_stream_rd_i,
   input  s_dma_str_out_t                  dma_stream_wr_i,
   output logic                            dma_abort_o,
   output logic                            dma_active_o,
   output logic                            dma_done_o,
   output logic                            dma_error_o,
   output logic                            dma_err_src_o,
   output desc_idx_t                       dma_err_idx_o
);

   dma_fsm_st_t r_state;
   dma_fsm_st_t w_state_nxt;
   desc_idx_t   r_idx;
   desc_idx_t   w_sel_idx;
   logic        w_sel_found;
   logic        r_rd_done;
   logic        r_wr_done;
   logic        w_rd_done;
   logic        w_wr_done;
   logic        w_launch;
   logic        w_advance;
   logic        w_err;
   logic        r_err_abort;
   logic        r_error;
   logic        r_err_src;
   desc_idx_t   r_err_idx;

   dma_desc_sel u_desc_sel (
      .i_desc      (dma_desc_i),
      .i_start_idx (r_idx),
      .o_found     (w_sel_found),
      .o_idx       (w_sel_idx)
   );

   assign w_rd_done = r_rd_done | dma_stream_rd_i.done;
   assign w_wr_done = r_wr_done | dma_stream_wr_i.done;
   assign w_err     = dma_rd_err_i | dma_wr_err_i;

   assign dma_abort_o   = dma_abort_i | r_err_abort;
   assign dma_active_o  = (r_state != IDLE);
   assign dma_done_o    = (r_state == DONE);
   assign dma_error_o   = r_error;
   assign dma_err_src_o = r_err_src;
   assign dma_err_idx_o = r_err_idx;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode and single-cycle stream launch
   always_comb begin
      w_state_nxt     = r_state;
      w_launch        = 1'b0;
      w_advance       = 1'b0;
      dma_stream_rd_o = '0;
      dma_stream_wr_o = '0;
      case (r_state)
         IDLE: if (dma_go_i) w_state_nxt = CFG;
         CFG: begin
            if (w_sel_found && !dma_abort_o) begin
               w_launch              = 1'b1;
               dma_stream_rd_o.valid = 1'b1;
               dma_stream_rd_o.idx   = w_sel_idx;
               dma_stream_wr_o.valid = 1'b1;
               dma_stream_wr_o.idx   = w_sel_idx;
               w_state_nxt           = RUN;
            end else begin
               w_state_nxt = DONE;
            end
         end
         RUN: begin
            if (w_rd_done && w_wr_done) begin
               if (dma_abort_o || (r_idx == desc_idx_t'(DMA_NUM_DESC - 1))) begin
                  w_state_nxt = DONE;
               end else begin
                  w_advance   = 1'b1;
                  w_state_nxt = CFG;
               end
            end
         end
         DONE: if (!dma_go_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Descriptor index and per-descriptor done latches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx     <= '0;
         r_rd_done <= 1'b0;
         r_wr_done <= 1'b0;
      end else begin
         if (r_state == IDLE) r_idx <= '0;
         else if (w_launch)   r_idx <= w_sel_idx;
         else if (w_advance)  r_idx <= r_idx + desc_idx_t'(1);

         if (w_launch) begin
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
         end else if (r_state == RUN) begin
            r_rd_done <= w_rd_done;
            r_wr_done <= w_wr_done;
         end
      end
   end

   // Sticky error flag with first-error source/index capture; read wins a tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_error   <= 1'b0;
         r_err_src <= 1'b0;
         r_err_idx <= '0;
      end else if (r_state == IDLE) begin
         r_error   <= 1'b0;
         r_err_src <= 1'b0;
         r_err_idx <= '0;
      end else if (w_err) begin
         r_error <= 1'b1;
         if (!r_error) begin
            r_err_src <= ~dma_rd_err_i;
            r_err_idx <= r_idx;
         end
      end
   end

`ifdef DMA_ERR_ABORT_EN
   // Error-driven abort, held until the sequencer returns to IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_err_abort <= 1'b0;
      else if (r_state == IDLE)  r_err_abort <= 1'b0;
      else if (w_err)            r_err_abort <= 1'b1;
   end
`else
   assign r_err_abort = 1'b0;
`endif

endmodule
